lvt_mpram: RTL and testbench

Generalised multi-port RAM: any number of read ports (NUM_RD ≥ 1) and write ports (NUM_WR ≥ 1), built as NUM_RD×NUM_WR banks with a live value table (LVT) that selects the freshest bank per read. Adds a configurable read pipeline with valid tracking, deterministic same-address write arbitration, and a hardware clear sequencer. Serves as the shared state store for the solver datapaths that need several lookups and updates per cycle.

---
 rtl/lvt_mpram_pkg.sv | 20 ++
 rtl/lvt_mpram_lvt.sv | 36 +++
 rtl/lvt_mpram.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_lvt_mpram.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvt_mpram_pkg.sv
// Shared types and helpers for the live-value-table multi-port RAM.
// State encoding for the clear sequencer plus parameter limits checked at elaboration.
package lvt_mpram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int MIN_RD_LAT = 1;
    localparam int MIN_PORTS  = 1;
    localparam int MIN_DEPTH  = 1;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lvt_mpram_lvt.sv
// Live value table: records which write port last touched each address.
// Highest-index port wins on same-address writes; registered (1-cycle) read per port.
module lvt_mpram_lvt
    import lvt_mpram_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int AW     = clog2_min1(DEPTH),
    parameter int IW     = clog2_min1(NUM_WR)
) (
    input  logic                           clk,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR-1:0][AW-1:0]      waddr_i,
    input  logic [NUM_RD-1:0][AW-1:0]      raddr_i,
    output logic [NUM_RD-1:0][IW-1:0]      rsel_o
);

    logic [IW-1:0] tbl_q [DEPTH];

    // Ascending loop: the last enabled port in index order takes the entry.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WR; w++) begin
            if (we_i[w]) begin
                tbl_q[waddr_i[w]] <= IW'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_RD; r++) begin
            rsel_o[r] <= tbl_q[raddr_i[r]];
        end
    end

endmodule

// File: rtl/lvt_mpram.sv
// Multi-port RAM built from NUM_WR x NUM_RD banks plus a live value table, with a
// hardware clear sweep. Define LVT_MPRAM_BYPASS_EN for write-first read behaviour.
module lvt_mpram
    import lvt_mpram_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int WIDTH  = 17,
    parameter int RD_LAT = 1,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int AW     = clog2_min1(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD-1:0][AW-1:0]       raddr,
    input  logic [NUM_RD-1:0]               ren,
    output logic [NUM_RD-1:0][WIDTH-1:0]    rdata,
    output logic [NUM_RD-1:0]               rvalid,
    input  logic [NUM_WR-1:0][AW-1:0]       waddr,
    input  logic [NUM_WR-1:0]               wen,
    input  logic [NUM_WR-1:0][WIDTH-1:0]    wdata,
    input  logic                            clr,
    output logic                            busy
);

    localparam int IW = clog2_min1(NUM_WR);

    if (RD_LAT < MIN_RD_LAT) begin : g_chk_lat
        $fatal(1, "lvt_mpram: RD_LAT must be >= 1");
    end
    if (NUM_RD < MIN_PORTS) begin : g_chk_rd
        $fatal(1, "lvt_mpram: NUM_RD must be >= 1");
    end
    if (NUM_WR < MIN_PORTS) begin : g_chk_wr
        $fatal(1, "lvt_mpram: NUM_WR must be >= 1");
    end
    if (DEPTH < MIN_DEPTH) begin : g_chk_depth
        $fatal(1, "lvt_mpram: DEPTH must be >= 1");
    end

    typedef logic [NUM_WR-1:0][WIDTH-1:0] words_t;

    typedef struct packed {
        logic              oor;
        logic [IW-1:0]     sel;
        logic              byp;
        logic [WIDTH-1:0]  byp_dat;
        words_t            words;
    } rd_stage_t;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Clear sequencer
    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == CLEAR);

    // Write side: the sweep owns every bank port while clearing; reset aborts it at once.
    logic                         clr_we;
    logic [NUM_WR-1:0]            wr_ok;
    logic [NUM_WR-1:0]            we;
    logic [NUM_WR-1:0]            lvt_we;
    logic [NUM_WR-1:0][AW-1:0]    wa;
    logic [NUM_WR-1:0][WIDTH-1:0] wd;

    assign clr_we = busy && !rst;

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wen[w] && in_range(waddr[w]) && !busy;
            if (clr_we) begin
                we[w]     = 1'b1;
                lvt_we[w] = (w == 0);
                wa[w]     = cnt_q;
                wd[w]     = '0;
            end else begin
                we[w]     = wr_ok[w];
                lvt_we[w] = wr_ok[w];
                wa[w]     = waddr[w];
                wd[w]     = wdata[w];
            end
        end
    end

    logic [NUM_RD-1:0]         ren_eff;
    logic [NUM_RD-1:0][AW-1:0] ra_c;

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            ren_eff[r] = ren[r] && !busy;
            ra_c[r]    = in_range(raddr[r]) ? raddr[r] : '0;
        end
    end

    // Stage 0: bank reads, LVT lookup and (optionally) bypass capture
    logic [WIDTH-1:0] bank_p0 [NUM_RD][NUM_WR];

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [WIDTH-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (we[w]) begin
                    mem_q[wa[w]] <= wd[w];
                end
                rd_q <= mem_q[ra_c[r]];
            end

            assign bank_p0[r][w] = rd_q;
        end
    end

    logic [NUM_RD-1:0][IW-1:0] sel_p0;

    lvt_mpram_lvt #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .AW     (AW),
        .IW     (IW)
    ) u_lvt (
        .clk     (clk),
        .we_i    (lvt_we),
        .waddr_i (wa),
        .raddr_i (ra_c),
        .rsel_o  (sel_p0)
    );

    logic [NUM_RD-1:0] vld_p0_q;
    logic [NUM_RD-1:0] oor_p0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q <= '0;
            oor_p0_q <= '0;
        end else begin
            vld_p0_q <= ren_eff;
            for (int r = 0; r < NUM_RD; r++) begin
                oor_p0_q[r] <= !in_range(raddr[r]);
            end
        end
    end

    logic [NUM_RD-1:0]            byp_p0;
    logic [NUM_RD-1:0][WIDTH-1:0] bypd_p0;

`ifdef LVT_MPRAM_BYPASS_EN
    logic [NUM_RD-1:0]            byp_d;
    logic [NUM_RD-1:0][WIDTH-1:0] bypd_d;

    // Later ports overwrite earlier matches so the winning write is forwarded.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            byp_d[r]  = 1'b0;
            bypd_d[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && (waddr[w] == raddr[r])) begin
                    byp_d[r]  = 1'b1;
                    bypd_d[r] = wdata[w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_p0  <= '0;
            bypd_p0 <= '0;
        end else begin
            byp_p0  <= byp_d;
            bypd_p0 <= bypd_d;
        end
    end
`else
    assign byp_p0  = '0;
    assign bypd_p0 = '0;
`endif

    rd_stage_t st_p0  [NUM_RD];
    rd_stage_t st_fin [NUM_RD];
    logic [NUM_RD-1:0] vld_fin;

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            st_p0[r]         = '0;
            st_p0[r].oor     = oor_p0_q[r];
            st_p0[r].sel     = sel_p0[r];
            st_p0[r].byp     = byp_p0[r];
            st_p0[r].byp_dat = bypd_p0[r];
            for (int w = 0; w < NUM_WR; w++) begin
                st_p0[r].words[w] = bank_p0[r][w];
            end
        end
    end

    // Stages 1..RD_LAT-1: carry all bank words plus the LVT select unchanged
    if (RD_LAT <= 1) begin : g_lat1
        assign vld_fin = vld_p0_q;
        for (genvar r = 0; r < NUM_RD; r++) begin : g_pass
            assign st_fin[r] = st_p0[r];
        end
    end else begin : g_latn
        rd_stage_t         pipe_q  [RD_LAT-1][NUM_RD];
        logic [NUM_RD-1:0] vpipe_q [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < RD_LAT - 1; k++) begin
                    vpipe_q[k] <= '0;
                    for (int r = 0; r < NUM_RD; r++) begin
                        pipe_q[k][r] <= '0;
                    end
                end
            end else begin
                vpipe_q[0] <= vld_p0_q;
                for (int r = 0; r < NUM_RD; r++) begin
                    pipe_q[0][r] <= st_p0[r];
                end
                for (int k = 1; k < RD_LAT - 1; k++) begin
                    vpipe_q[k] <= vpipe_q[k-1];
                    for (int r = 0; r < NUM_RD; r++) begin
                        pipe_q[k][r] <= pipe_q[k-1][r];
                    end
                end
            end
        end

        assign vld_fin = vpipe_q[RD_LAT-2];
        for (genvar r = 0; r < NUM_RD; r++) begin : g_tap
            assign st_fin[r] = pipe_q[RD_LAT-2][r];
        end
    end

    // Final stage: LVT select, out-of-range forcing to zero, hold when idle
    logic [NUM_RD-1:0][WIDTH-1:0] sel_word;
    logic [NUM_RD-1:0][WIDTH-1:0] hold_q;

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            if (st_fin[r].oor) begin
                sel_word[r] = '0;
            end else if (st_fin[r].byp) begin
                sel_word[r] = st_fin[r].byp_dat;
            end else begin
                sel_word[r] = st_fin[r].words[st_fin[r].sel];
            end
            rdata[r] = vld_fin[r] ? sel_word[r] : hold_q[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (vld_fin[r]) begin
                    hold_q[r] <= sel_word[r];
                end
            end
        end
    end

    assign rvalid = vld_fin;

endmodule

// File: tb/tb_lvt_mpram.sv
// Bench for lvt_mpram: a memory/queue model checked every cycle, plus directed literal checks.
module tb_lvt_mpram;

    localparam int DEPTH = 12;
    localparam int W     = 17;
    localparam int LAT   = 3;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NR-1:0][AW-1:0]     raddr;
    logic [NR-1:0]             ren;
    logic [NR-1:0][W-1:0]      rdata;
    logic [NR-1:0]             rvalid;
    logic [NW-1:0][AW-1:0]     waddr;
    logic [NW-1:0]             wen;
    logic [NW-1:0][W-1:0]      wdata;
    logic                      clr;
    logic                      busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lvt_mpram #(
        .DEPTH  (DEPTH),
        .WIDTH  (W),
        .RD_LAT (LAT),
        .NUM_RD (NR),
        .NUM_WR (NW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raddr  (raddr),
        .ren    (ren),
        .rdata  (rdata),
        .rvalid (rvalid),
        .waddr  (waddr),
        .wen    (wen),
        .wdata  (wdata),
        .clr    (clr),
        .busy   (busy)
    );

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Behavioural model: a plain word array, a clear countdown, and per-port queues of
    // pending read results tagged with the cycle at which they must appear.
    typedef struct {
        int due;
        int dat;
    } pend_t;

    int    mdl [DEPTH];
    pend_t pq [NR][$];
    int    cyc = 0;
    bit    busy_m = 1'b0;
    int    cidx = 0;
    int    held [NR];
    bit    exp_v [NR];
    int    exp_d [NR];
    bit    exp_busy = 1'b0;
    bit    chk_on = 1'b0;

    always @(posedge clk) begin
        pend_t p;
        int    v;
        cyc++;
        if (rst) begin
            busy_m = 1'b0;
            chk_on = 1'b1;
            for (int r = 0; r < NR; r++) begin
                pq[r].delete();
                held[r] = 0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (ren[r] && !busy_m) begin
                    v = 0;
                    if (int'(raddr[r]) < DEPTH) v = mdl[int'(raddr[r])];
`ifdef LVT_MPRAM_BYPASS_EN
                    for (int w = 0; w < NW; w++)
                        if (wen[w] && int'(waddr[w]) < DEPTH && waddr[w] == raddr[r])
                            v = int'(wdata[w]);
`endif
                    p.due = cyc + LAT - 1;
                    p.dat = v;
                    pq[r].push_back(p);
                end
            end
            if (busy_m) begin
                mdl[cidx] = 0;
                cidx++;
                if (cidx == DEPTH) busy_m = 1'b0;
            end else begin
                for (int w = 0; w < NW; w++)
                    if (wen[w] && int'(waddr[w]) < DEPTH) mdl[int'(waddr[w])] = int'(wdata[w]);
                if (clr) begin
                    busy_m = 1'b1;
                    cidx   = 0;
                end
            end
        end
        exp_busy = busy_m;
        for (int r = 0; r < NR; r++) begin
            if (pq[r].size() > 0 && pq[r][0].due == cyc) begin
                exp_v[r] = 1'b1;
                exp_d[r] = pq[r][0].dat;
                held[r]  = pq[r][0].dat;
                void'(pq[r].pop_front());
            end else begin
                exp_v[r] = 1'b0;
                exp_d[r] = held[r];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", int'(busy), int'(exp_busy));
            for (int r = 0; r < NR; r++) begin
                chk($sformatf("rvalid%0d", r), int'(rvalid[r]), int'(exp_v[r]));
                chk($sformatf("rdata%0d", r), int'(rdata[r]), exp_d[r]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ren = '0;
        wen = '0;
        clr = 1'b0;
    endtask

    task automatic step();
        tick();
        idle();
    endtask

    task automatic wr(input int port, input int addr, input int data);
        wen[port]   = 1'b1;
        waddr[port] = AW'(addr);
        wdata[port] = W'(data);
    endtask

    task automatic rd(input int port, input int addr);
        ren[port]   = 1'b1;
        raddr[port] = AW'(addr);
    endtask

    task automatic rd_lit(input string nm, input int port, input int addr, input int exp);
        idle();
        rd(port, addr);
        step();
        repeat (LAT - 1) tick();
        chk({nm, "_v"}, int'(rvalid[port]), 1);
        chk(nm, int'(rdata[port]), exp);
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("reset_rvalid%0d", r), int'(rvalid[r]), 0);
            chk($sformatf("reset_rdata%0d", r), int'(rdata[r]), 0);
        end

        clr = 1'b1;
        step();
        chk("clr0_busy_rise", int'(busy), 1);
        wait_clear(n);
        chk("clr0_len", n, DEPTH);

        // Two writes to the same word on different ports, then a read on every port
        wr(0, 5, 'h11);
        step();
        wr(1, 5, 'h22);
        step();
        step();
        for (int r = 0; r < NR; r++) rd(r, 5);
        step();
        repeat (LAT - 1) tick();
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("latest_v%0d", r), int'(rvalid[r]), 1);
            chk($sformatf("latest_d%0d", r), int'(rdata[r]), 'h22);
        end

        wr(0, 7, 'hA);
        wr(1, 7, 'hB);
        step();
        rd_lit("conflict", 2, 7, 'hB);

        // Read and write of the same address in one cycle
        wr(0, 9, 'h3);
        step();
        wr(1, 9, 'h4);
        rd(0, 9);
        step();
        repeat (LAT - 1) tick();
`ifdef LVT_MPRAM_BYPASS_EN
        chk("rw_same_cycle", int'(rdata[0]), 'h4);
`else
        chk("rw_same_cycle", int'(rdata[0]), 'h3);
`endif
        rd_lit("rw_after", 1, 9, 'h4);

        for (int i = 0; i < 10; i++) begin
            wr(i % 2, i, 'h100 + i);
            step();
        end
        n = 0;
        first = -1;
        for (int k = 0; k < 16; k++) begin
            if (k < 10) rd(1, k);
            tick();
            idle();
            if (rvalid[1]) begin
                if (first < 0) first = k;
                n++;
                chk("b2b_data", int'(rdata[1]), 'h100 + n - 1);
            end
        end
        chk("b2b_count", n, 10);
        chk("b2b_first", first, LAT - 1);

        wr(0, 13, 'h1ABCD);
        step();
        rd_lit("oor_read", 0, 13, 0);
        rd_lit("oor_clamp", 2, 0, 'h100);

        // Full clear with traffic attempted mid-sweep
        for (int i = 0; i < DEPTH; i++) begin
            wr(i % 2, i, 'h200 + i);
            step();
        end
        clr = 1'b1;
        step();
        chk("clr1_busy_rise", int'(busy), 1);
        n = 0;
        while (busy && n < 200) begin
            if (n == 2) begin
                wr(1, 3, 'h3333);
                rd(0, 3);
            end
            if (n == 4) clr = 1'b1;
            tick();
            idle();
            n++;
        end
        chk("clr1_len", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) rd_lit($sformatf("cleared%0d", i), i % NR, i, 0);

        // Reset in the middle of a sweep
        for (int i = 0; i < 5; i++) begin
            wr(0, i, 'h300 + i);
            step();
        end
        wr(1, 10, 'h55);
        step();
        clr = 1'b1;
        step();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        for (int r = 0; r < NR; r++) chk($sformatf("abort_rvalid%0d", r), int'(rvalid[r]), 0);
        for (int i = 0; i < 4; i++) rd_lit($sformatf("abort_clr%0d", i), i % NR, i, 0);
        rd_lit("abort_keep4", 1, 4, 'h304);
        rd_lit("abort_keep10", 2, 10, 'h55);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
